regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32, sets the register width in bits.
REQ-002 Parameter ADDR_W, default 5, sets the address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, default 2, sets the number of combinational read ports.
REQ-004 Parameter NUM_WR, default 2, sets the number of write ports.
REQ-005 Parameter ZERO_REG, default 1, hardwires entry 0 to zero when set to 1.
REQ-006 Parameter BYPASS, default 1, forwards same-cycle write data to reads when set to 1.
REQ-007 Parameter INIT_VAL, default 0, DATA_W wide, is the value written to every entry during init.
REQ-008 clk  in  1  sole clock; all state updates on the rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-011 rd_data  out  NUM_RD*DATA_W  packed read data; port i occupies bits [i*DATA_W +: DATA_W].
REQ-012 wr_en  in  NUM_WR  per-port write enable.
REQ-013 wr_addr  in  NUM_WR*ADDR_W  packed write addresses.
REQ-014 wr_data  in  NUM_WR*DATA_W  packed write data.
REQ-015 ready  out  1  high once init completes; writes are accepted only while high.

Function
REQ-016 The block SHALL implement a two-state FSM, INIT and RUN, with a counter init_idx of ADDR_W bits.
REQ-017 In INIT, each cycle the block SHALL write INIT_VAL to entry init_idx and increment init_idx.
REQ-018 INIT SHALL advance to RUN in the cycle that writes entry DEPTH-1, so ready rises exactly DEPTH cycles after reset deasserts.
REQ-019 In INIT, wr_en SHALL be ignored, and every rd_data port SHALL return 0.
REQ-020 In RUN, each port w with wr_en[w]=1 SHALL write wr_data[w] to entry wr_addr[w] at the rising edge.
REQ-021 If several enabled ports target the same address, the highest-indexed port SHALL win.
REQ-022 Reads SHALL be combinational, with zero-cycle latency: rd_data[i] = entry rd_addr[i].
REQ-023 With BYPASS=1 in RUN, a read whose address matches an enabled same-cycle write SHALL return that write's data, using the REQ-021 priority.
REQ-024 With BYPASS=0, a read SHALL return the pre-edge contents, so the write becomes visible on the next cycle.
REQ-025 With ZERO_REG=1, reads of address 0 SHALL return 0 and writes to address 0 SHALL be discarded, both without bypass.
REQ-026 All address arithmetic SHALL be modulo DEPTH; init_idx wrap marks the end of INIT and SHALL NOT restart it.

Reset
REQ-027 Reset asserted at any clock edge, including mid-INIT or mid-write, SHALL force INIT, set init_idx=0 and set ready=0 on that edge.
REQ-028 Writes presented in the same cycle as reset SHALL be dropped.
REQ-029 Register contents SHALL NOT be cleared by reset directly; they are cleared only by the INIT sweep.
REQ-030 While reset is held high, init_idx SHALL stay at 0 and ready SHALL stay at 0.

Structure
REQ-031 A shared package regfile_pkg SHALL hold the state enum type (INIT, RUN) and the default parameter constants.
REQ-032 One sub-module, regfile_wr_arb, SHALL resolve per-address write priority and bypass selection.
REQ-033 Storage SHALL be a single DEPTH x DATA_W array, and no latches SHALL be inferred.

Verification
REQ-034 Reset high for 1 cycle, then low -> ready=0 for 32 cycles and 1 on cycle 32; all reads return 0 afterwards.
REQ-035 RUN, write port0 addr 3 = 0x0000_0006 with rd_addr0=3 in the same cycle -> rd_data0=0x6 that cycle (BYPASS=1); with BYPASS=0, 0 that cycle and 0x6 the next.
REQ-036 Port0 writes addr 7=0xAAAA_AAAA and port1 writes addr 7=0x5555_5555 in the same cycle -> entry 7 reads 0x5555_5555.
REQ-037 Write addr 0=0xFFFF_FFFF -> read addr 0 returns 0 in the same cycle and the next.
REQ-038 Reset pulsed at INIT cycle 10 after prior RUN data in entry 20 -> ready low, sweep restarts at idx 0, and entry 20 reads INIT_VAL after ready rises.
REQ-039 wr_en asserted during INIT to addr 5=0x1234 -> after ready rises, entry 5 = INIT_VAL.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types and default parameter constants for the
//                multi-ported register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Sequencer state: sweep INIT_VAL into every entry, then serve traffic.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default parameter values shared by the top and sub-module.
    localparam int c_def_data_w   = 32;
    localparam int c_def_addr_w   = 5;
    localparam int c_def_num_rd   = 2;
    localparam int c_def_num_wr   = 2;
    localparam int c_def_zero_reg = 1;
    localparam int c_def_bypass   = 1;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arb
//  Description : Resolves same-address write conflicts (highest port wins),
//                drops writes to the hardwired zero entry, and picks the
//                forwarding data for each read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_def_data_w,
    parameter int ADDR_W   = c_def_addr_w,
    parameter int NUM_RD   = c_def_num_rd,
    parameter int NUM_WR   = c_def_num_wr,
    parameter int ZERO_REG = c_def_zero_reg
) (
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_WR-1:0]        wr_commit,
    output logic [NUM_RD-1:0]        rd_hit,
    output logic [NUM_RD*DATA_W-1:0] rd_byp_data
);

    // A port commits only if no higher-indexed enabled port hits the same entry.
    always_comb begin
        wr_commit = wr_en;
        for (int w = 0; w < NUM_WR; w++) begin
            if ((ZERO_REG != 0) && (wr_addr[w*ADDR_W +: ADDR_W] == '0)) begin
                wr_commit[w] = 1'b0;
            end
            for (int v = w + 1; v < NUM_WR; v++) begin
                if (wr_en[v] && (wr_addr[v*ADDR_W +: ADDR_W] == wr_addr[w*ADDR_W +: ADDR_W])) begin
                    wr_commit[w] = 1'b0;
                end
            end
        end
    end

    // Forwarding select: scanning ports upward lets the highest match win.
    always_comb begin
        rd_hit      = '0;
        rd_byp_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W])) begin
                    rd_hit[r]                     = 1'b1;
                    rd_byp_data[r*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule : regfile_wr_arb
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : Parameterised multi-read / multi-write register file with an
//                initialisation sweep after reset, optional zero entry and
//                optional same-cycle write-to-read forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int                DATA_W   = c_def_data_w,
    parameter int                ADDR_W   = c_def_addr_w,
    parameter int                NUM_RD   = c_def_num_rd,
    parameter int                NUM_WR   = c_def_num_wr,
    parameter int                ZERO_REG = c_def_zero_reg,
    parameter int                BYPASS   = c_def_bypass,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     ready
);

    localparam int                DEPTH       = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_idx  = {ADDR_W{1'b1}};

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_init_idx;
    logic [ADDR_W-1:0]   w_init_idx_next;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic [NUM_WR-1:0]        w_wr_en_run;
    logic [NUM_WR-1:0]        w_wr_commit;
    logic [NUM_RD-1:0]        w_rd_hit;
    logic [NUM_RD*DATA_W-1:0] w_rd_byp_data;

    assign ready = (r_state == RUN);

    // Writes count only in RUN and never in a reset cycle.
    assign w_wr_en_run = wr_en & {NUM_WR{ready & ~reset}};

    regfile_wr_arb #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_wr_arb (
        .wr_en       (w_wr_en_run),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .wr_commit   (w_wr_commit),
        .rd_hit      (w_rd_hit),
        .rd_byp_data (w_rd_byp_data)
    );

    // State and sweep-counter register; reset restarts the sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= INIT;
            r_init_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_idx <= w_init_idx_next;
        end
    end

    // Next state: leave INIT on the cycle that writes the last entry.
    always_comb begin
        w_state_next    = r_state;
        w_init_idx_next = r_init_idx;
        case (r_state)
            INIT: begin
                w_init_idx_next = r_init_idx + 1'b1;
                if (r_init_idx == c_last_idx) begin
                    w_state_next = RUN;
                end
            end
            RUN:     w_state_next = RUN;
            default: w_state_next = INIT;
        endcase
    end

    // Storage update: sweep write in INIT, arbitrated port writes in RUN.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == INIT) begin
                r_mem[r_init_idx] <= INIT_VAL;
            end else begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (w_wr_commit[w]) begin
                        r_mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Combinational read: zero in INIT, zero entry, then forwarding, then array.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (r_state == RUN) begin
                if ((ZERO_REG != 0) && (rd_addr[r*ADDR_W +: ADDR_W] == '0)) begin
                    rd_data[r*DATA_W +: DATA_W] = '0;
                end else if ((BYPASS != 0) && w_rd_hit[r]) begin
                    rd_data[r*DATA_W +: DATA_W] = w_rd_byp_data[r*DATA_W +: DATA_W];
                end else begin
                    rd_data[r*DATA_W +: DATA_W] = r_mem[rd_addr[r*ADDR_W +: ADDR_W]];
                end
            end
        end
    end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Scoreboard bench for regfile_mp. Two instances share stimulus:
//                dut_a uses defaults (forwarding on, INIT_VAL 0); dut_b has
//                forwarding off and a non-zero INIT_VAL.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    localparam logic [31:0] c_ib = 32'h1111_2222;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        ready_a;
    logic        ready_b;

    always #5 clk = ~clk;

    regfile_mp dut_a (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_data (rd_data_a),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready_a)
    );

    regfile_mp #(
        .BYPASS   (0),
        .INIT_VAL (c_ib)
    ) dut_b (
        .clk     (clk),
        .reset   (reset),
        .rd_addr (rd_addr),
        .rd_data (rd_data_b),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready_b)
    );

    // Scoreboard entry: sig selects which DUT output is compared.
    typedef struct {
        logic [127:0] name;
        int           sig;
        logic [31:0]  exp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input logic [127:0] nm, input int sig, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.sig  = sig;
        e.exp  = v;
        q.push_back(e);
    endtask

    // Expect both instances: a0/a1 for dut_a read ports, b0/b1 for dut_b.
    task automatic push_rd(input logic [127:0] nm, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] b0, input logic [31:0] b1);
        push(nm, 0, a0);
        push(nm, 1, a1);
        push(nm, 3, b0);
        push(nm, 4, b1);
    endtask

    task automatic push_ready(input logic [127:0] nm, input logic v);
        push(nm, 2, {31'b0, v});
        push(nm, 5, {31'b0, v});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                          input logic [4:0] a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    // Monitor: outputs are settled by the falling edge; drain this cycle's entries.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sig)
                0:       act = rd_data_a[31:0];
                1:       act = rd_data_a[63:32];
                2:       act = {31'b0, ready_a};
                3:       act = rd_data_b[31:0];
                4:       act = rd_data_b[63:32];
                default: act = {31'b0, ready_b};
            endcase
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %0s sig%0d: got %h expected %h at %0t", e.name, e.sig, act, e.exp, $time);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        rd_addr = {5'd31, 5'd5};
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

        // Reset held for two edges: ready low, reads zero.
        for (int i = 0; i < 2; i++) begin
            cyc();
            push_ready("rst_ready", 1'b0);
            push_rd("rst_rd", 32'h0, 32'h0, 32'h0, 32'h0);
        end

        // Release reset; attempt writes to entry 5 throughout the sweep.
        reset = 1'b0;
        set_wr(2'b01, 5'd5, 32'h0000_1234, 5'd0, 32'h0);
        for (int i = 1; i <= 32; i++) begin
            cyc();
            if (i == 32) begin
                set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
                push_ready("init_done", 1'b1);
                push_rd("init_done_rd", 32'h0, 32'h0, c_ib, c_ib);
            end else begin
                push_ready("init_ready", 1'b0);
                push_rd("init_rd", 32'h0, 32'h0, 32'h0, 32'h0);
            end
        end

        // Sweep every entry: INIT_VAL everywhere, zero at entry 0.
        for (int a = 0; a < 32; a++) begin
            cyc();
            rd_addr = {5'(31 - a), 5'(a)};
            push_rd("sweep", 32'h0, 32'h0,
                    (a == 0) ? 32'h0 : c_ib, (a == 31) ? 32'h0 : c_ib);
        end

        // Same-cycle write/read of entry 3.
        cyc();
        rd_addr = {5'd3, 5'd3};
        set_wr(2'b01, 5'd3, 32'h0000_0006, 5'd0, 32'h0);
        push_rd("byp_wr3", 32'h6, 32'h6, c_ib, c_ib);
        cyc();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        push_rd("after_wr3", 32'h6, 32'h6, 32'h6, 32'h6);

        // Both ports hit entry 7: port1 wins.
        cyc();
        rd_addr = {5'd7, 5'd7};
        set_wr(2'b11, 5'd7, 32'hAAAA_AAAA, 5'd7, 32'h5555_5555);
        push_rd("prio_byp7", 32'h5555_5555, 32'h5555_5555, c_ib, c_ib);
        cyc();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        push_rd("prio_wr7", 32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555);

        // Distinct addresses on both ports.
        cyc();
        rd_addr = {5'd10, 5'd9};
        set_wr(2'b11, 5'd9, 32'h0000_0099, 5'd10, 32'h0000_00A0);
        push_rd("dual_byp", 32'h99, 32'hA0, c_ib, c_ib);
        cyc();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        push_rd("dual_wr", 32'h99, 32'hA0, 32'h99, 32'hA0);

        // Entry 0 stays zero; port1 on entry 0 must not block port0.
        cyc();
        rd_addr = {5'd11, 5'd0};
        set_wr(2'b11, 5'd11, 32'h0000_0BBB, 5'd0, 32'hFFFF_FFFF);
        push_rd("zero_byp", 32'h0, 32'hBBB, 32'h0, c_ib);
        cyc();
        set_wr(2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0);
        push_rd("zero_wr", 32'h0, 32'hBBB, 32'h0, 32'hBBB);
        cyc();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        push_rd("zero_next", 32'h0, 32'hBBB, 32'h0, 32'hBBB);

        // Put data in entry 20, then reset and re-reset mid-sweep.
        cyc();
        rd_addr = {5'd3, 5'd20};
        set_wr(2'b01, 5'd20, 32'hDEAD_BEEF, 5'd0, 32'h0);
        cyc();
        set_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        push_rd("entry20", 32'hDEAD_BEEF, 32'h6, 32'hDEAD_BEEF, 32'h6);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        push_ready("rst1_ready", 1'b0);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            push_ready("mid_init", 1'b0);
        end
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        push_ready("rst2_ready", 1'b0);
        for (int i = 1; i <= 32; i++) begin
            cyc();
            push_ready("reinit", (i == 32) ? 1'b1 : 1'b0);
        end
        push_rd("reinit_rd", 32'h0, 32'h0, c_ib, c_ib);
        cyc();
        rd_addr = {5'd9, 5'd7};
        push_rd("reinit_rd2", 32'h0, 32'h0, c_ib, c_ib);

        // Drain and confirm every queued expectation was compared.
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_mp
`default_nettype wire
